// File: rtl/aes_stream_arbiter.sv
// aes_stream_arbiter
//   Round-robin front end and in-order back end for a fixed-latency pipelined
//   AES-128 core. Blocks from NUM_CH valid/ready channels are issued to the
//   core at up to one per cycle. Each block's channel ID rides a tag delay line
//   matched to the core latency. Results are queued in a first-word-fall-through
//   FIFO. Admission is credit based, so the FIFO cannot overflow while the
//   downstream side applies backpressure.
//
// Ports
//   clk, reset        clock, asynchronous active-low reset (shared with the core)
//   s_valid/s_ready   per-channel handshake; s_data/s_key hold channel i at [i*W +: W]
//   core_*            issue register to the core, plus the core's result inputs
//   m_valid/m_ready   result handshake; m_data is the ciphertext, m_ch its source channel
//   credits           FIFO_DEPTH minus blocks issued but not yet popped
//   err_sync          sticky: the tag line and core_valid_out disagreed
//   err_ovf           sticky: a result arrived at a full FIFO with no pop
module aes_stream_arbiter #(
  parameter int DATA_W     = 128,
  parameter int KEY_L      = 128,
  parameter int NUM_CH     = 4,
  parameter int ID_W       = $clog2(NUM_CH),
  parameter int CORE_LAT   = 41,
  parameter int FIFO_DEPTH = 64,
  parameter int CRED_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        s_valid,
  output logic [NUM_CH-1:0]        s_ready,
  input  logic [NUM_CH*DATA_W-1:0] s_data,
  input  logic [NUM_CH*KEY_L-1:0]  s_key,
  output logic                     core_valid,
  output logic                     core_key_valid,
  output logic [DATA_W-1:0]        core_data,
  output logic [KEY_L-1:0]         core_key,
  input  logic                     core_valid_out,
  input  logic [DATA_W-1:0]        core_data_out,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_W-1:0]        m_data,
  output logic [ID_W-1:0]          m_ch,
  output logic [CRED_W-1:0]        credits,
  output logic                     err_sync,
  output logic                     err_ovf
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CRED_W-1:0] DEPTH_C = CRED_W'(FIFO_DEPTH);

  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   issue_id;
  logic              grant_valid;
  logic              can_issue;
  logic              accept;
  logic              pop;
  logic              fifo_wr;
  logic              fifo_full;
  logic [CRED_W-1:0] outstanding;
  logic [CRED_W-1:0] fifo_count;
  int                scan_idx;

  logic [CORE_LAT-1:0] tag_v;
  logic [ID_W-1:0]     tag_id [CORE_LAT];

  logic [ID_W+DATA_W-1:0] mem [FIFO_DEPTH];
  logic [ID_W+DATA_W-1:0] head;
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Rotating-priority search starting at ptr.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    scan_idx    = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan_idx = int'(ptr) + i;
      if (scan_idx >= NUM_CH) scan_idx = scan_idx - NUM_CH;
      if (!grant_valid && s_valid[scan_idx]) begin
        grant_valid = 1'b1;
        grant       = ID_W'(scan_idx);
      end
    end
  end

  // Admission looks only at outstanding, never at m_ready, so s_ready has no
  // combinational path from the downstream side.
  assign can_issue = (outstanding < DEPTH_C);
  assign accept    = grant_valid & can_issue;
  assign s_ready   = accept ? (NUM_CH'(1) << grant) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr            <= '0;
      core_valid     <= 1'b0;
      core_key_valid <= 1'b0;
      core_data      <= '0;
      core_key       <= '0;
      issue_id       <= '0;
    end else begin
      core_valid     <= accept;
      core_key_valid <= accept;
      if (accept) begin
        ptr       <= (grant == ID_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
        core_data <= s_data[int'(grant)*DATA_W +: DATA_W];
        core_key  <= s_key[int'(grant)*KEY_L +: KEY_L];
        issue_id  <= grant;
      end
    end
  end

  // Stage 0 loads one cycle after core_valid, so the last stage lines up with
  // core_valid_out for a core of exactly CORE_LAT cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_v <= '0;
      for (int i = 0; i < CORE_LAT; i++) tag_id[i] <= '0;
    end else begin
      tag_v     <= {tag_v[CORE_LAT-2:0], core_valid};
      tag_id[0] <= issue_id;
      for (int i = 1; i < CORE_LAT; i++) tag_id[i] <= tag_id[i-1];
    end
  end

  assign m_valid   = (fifo_count != '0);
  assign fifo_full = (fifo_count == DEPTH_C);
  assign pop       = m_valid & m_ready;
  // A write at full is fine when the head leaves in the same cycle.
  assign fifo_wr   = core_valid_out & (~fifo_full | pop);
  assign head      = mem[rd_ptr];
  assign m_data    = m_valid ? head[DATA_W-1:0] : '0;
  assign m_ch      = m_valid ? head[ID_W+DATA_W-1:DATA_W] : '0;
  assign credits   = DEPTH_C - outstanding;

  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr] <= {tag_id[CORE_LAT-1], core_data_out};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      outstanding <= '0;
      err_sync    <= 1'b0;
      err_ovf     <= 1'b0;
    end else begin
      if (fifo_wr) wr_ptr <= wrap_inc(wr_ptr);
      if (pop)     rd_ptr <= wrap_inc(rd_ptr);
      case ({fifo_wr, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      // The zero guard keeps a spurious result (sync error) from wrapping the count.
      if (accept && !pop)
        outstanding <= outstanding + 1'b1;
      else if (pop && !accept && outstanding != '0)
        outstanding <= outstanding - 1'b1;
      if (tag_v[CORE_LAT-1] != core_valid_out) err_sync <= 1'b1;
      if (core_valid_out && fifo_full && !pop) err_ovf <= 1'b1;
    end
  end

endmodule
